act_loader: RTL and testbench
=============================

# act_loader

Responder for the controller's `load_en`/`load_done` handshake in the MNIST MLP datapath. When the controller enters its LOAD phase, this block captures the activated outputs of the layer just computed and writes them serially into the input/activation buffer, at the addresses the controller will later sweep. It then returns `load_done`. After the output layer is loaded, it also computes the predicted class by argmax over the output activations.

## Interface
Parameters:
- `NO_HL`, 2: number of hidden layers.
- `NO_NIL`, 784: number of input-layer neurons; the first loader write address.
- `NO_NHL`, 28: neurons per hidden layer; also the width of the parallel capture bus, in lanes.
- `NO_NOL`, 10: output-layer neurons.
- `DATA_W`, 8: bits per activation. Values are unsigned, post-ReLU.

Ports:
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous reset, active-low.
- `start`  in  1: new-inference pulse from the top level. It is the same signal the controller sees.
- `load_en`  in  1: level from the controller. It stays high until `load_done` is accepted.
- `act_vec`  in  NO_NHL*DATA_W: activated neuron outputs. Lane i occupies bits [i*DATA_W +: DATA_W]. Only lanes below the current layer size are used.
- `wr_en`  out  1: buffer write strobe.
- `wr_addr`  out  11: buffer write address.
- `wr_data`  out  DATA_W: buffer write data.
- `load_done`  out  1: single-cycle pulse that ends the handshake.
- `pred`  out  4: predicted class index, 0..NO_NOL-1.
- `pred_valid`  out  1: `pred` is valid.
- `layer_idx`  out  clog2(NO_HL+1): index of the layer being (or next to be) loaded.

## Operation
- Layer sequence:
  - `layer_idx` 0..NO_HL-1 are hidden layers, each of size NO_NHL.
  - `layer_idx` NO_HL is the output layer, of size NO_NOL.
  - Write base starts at NO_NIL and advances by the loaded layer size after each load: 784, 812, 840 for the default parameters.
- FSM states: IDLE, CAPTURE, WRITE, DONE, WAIT_LOW.
  - IDLE: when `load_en` is 1, go to CAPTURE.
  - CAPTURE: register all of `act_vec` into an internal array, clear the element counter `i`, go to WRITE.
  - WRITE:
    - Drive `wr_en`=1, `wr_addr`=base+i, `wr_data`=lane i.
    - Increment `i`.
    - After the last element (i = size-1), go to DONE.
  - DONE:
    - `load_done`=1 for exactly one cycle.
    - Advance base and `layer_idx`.
    - If the loaded layer was the output layer: `layer_idx` wraps to 0, base resets to NO_NIL, `pred_valid` is set.
    - Go to WAIT_LOW.
  - WAIT_LOW: stay until `load_en` is 0, then go to IDLE. This prevents re-triggering on a `load_en` that is still high.
- Argmax, output layer only:
  - Runs alongside WRITE, comparing each lane against a running maximum.
  - Comparison is unsigned, strict greater-than, so ties resolve to the lowest index.
  - `pred` is updated at the DONE edge.
- `start` (any state):
  - Clears `layer_idx`, resets base to NO_NIL, clears `pred_valid`, returns to IDLE.
  - If the block is in WRITE, `wr_en` is 0 from the next cycle; the partial load is abandoned and no `load_done` is issued.
  - `start` and `load_en` high in the same IDLE cycle: `start` wins; `load_en` is evaluated on the following cycle.
- `load_en` dropping during CAPTURE or WRITE is ignored; the load completes and `load_done` still pulses.
- `pred`/`pred_valid` hold their values until the next `start` or reset.

## Timing
- Reset values: all outputs 0, state IDLE, base NO_NIL. Reset takes effect asynchronously.
- Latency: with `load_en` first sampled high at edge 0, writes occur on cycles 2..size+1 and `load_done` is high in cycle size+2.
  - Hidden layer: 30 cycles.
  - Output layer: 12 cycles.
- `wr_en`, `wr_addr`, `wr_data` are registered outputs and change only on clock edges.
- `load_done` is registered and never high for two consecutive cycles.
- `pred_valid` rises in the same cycle as the output layer's `load_done`.
- `wr_addr` is 11 bits. The last write with default parameters is 849, which fits without wrap. The address is never reduced modulo 2^11.

## Test plan
- Hidden load: reset, hold `load_en` high, `act_vec` lane i = i+1 -> 28 writes at addresses 784..811 with data 1..28, `load_done` one cycle in cycle 30, `layer_idx`=1.
- Full inference: three consecutive handshakes -> write bases 784, 812, 840. The output layer has lanes 0..9 = {3,9,2,9,0,0,0,0,0,1} -> `pred`=1 (tie goes to the lower index), `pred_valid`=1, `layer_idx`=0.
- `load_en` held high 5 cycles after `load_done` -> no second capture; the block returns to IDLE only after `load_en`=0.
- `start` asserted during the 10th write of a hidden layer -> `wr_en` low the next cycle, no `load_done`, base 784, `layer_idx`=0, `pred_valid` cleared.
- `load_en` dropped after 3 writes -> all 28 writes complete and `load_done` pulses.
- `rst` low mid-WRITE, asynchronously -> `wr_en`, `load_done`, `pred_valid` all 0 immediately; the next load writes from 784.

Source files
------------

// File: rtl/act_loader_if.sv
// Bus between the MLP controller/datapath and the activation loader.
// Handshake: load_en is a level request from the controller that stays high
// until load_done (a one-cycle pulse) is seen; the loader re-arms only after
// load_en has returned low. start is a pulse that aborts any load in flight.
// wr_en/wr_addr/wr_data is a fire-and-forget write port into the buffer:
// every cycle with wr_en high is one accepted write, with no back-pressure.
interface act_loader_if #(
  parameter int NO_HL  = 2,
  parameter int NO_NHL = 28,
  parameter int DATA_W = 8
);
  localparam int LW = $clog2(NO_HL + 1);

  logic                     start;
  logic                     load_en;
  logic [NO_NHL*DATA_W-1:0] act_vec;
  logic                     wr_en;
  logic [10:0]              wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     load_done;
  logic [3:0]               pred;
  logic                     pred_valid;
  logic [LW-1:0]            layer_idx;
  logic [2:0]               dbg_state;

  modport master (
    output start, load_en, act_vec,
    input  wr_en, wr_addr, wr_data, load_done, pred, pred_valid, layer_idx,
           dbg_state
  );

  modport slave (
    input  start, load_en, act_vec,
    output wr_en, wr_addr, wr_data, load_done, pred, pred_valid, layer_idx,
           dbg_state
  );
endinterface

// File: rtl/act_loader.sv
// Activation loader: captures a layer's activated outputs, writes them
// serially into the activation buffer, pulses load_done, and computes the
// argmax of the output layer as the predicted class.
module act_loader #(
  parameter int NO_HL  = 2,
  parameter int NO_NIL = 784,
  parameter int NO_NHL = 28,
  parameter int NO_NOL = 10,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  act_loader_if.slave  bus
);
  localparam int ADDR_W = 11;
  localparam int LW     = $clog2(NO_HL + 1);
  localparam int CW     = $clog2(NO_NHL + 1);
  localparam logic [CW-1:0]     HID_SZ  = CW'(NO_NHL);
  localparam logic [CW-1:0]     OUT_SZ  = CW'(NO_NOL);
  localparam logic [ADDR_W-1:0] BASE0   = ADDR_W'(NO_NIL);
  localparam logic [LW-1:0]     OUT_IDX = LW'(NO_HL);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURE  = 3'd1,
    S_WRITE    = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_LOW = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_act [NO_NHL];
  logic [CW-1:0]       r_i;
  logic [ADDR_W-1:0]   r_base;
  logic [LW-1:0]       r_layer;
  logic [DATA_W-1:0]   r_max;
  logic [CW-1:0]       r_arg;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_load_done;
  logic [3:0]          r_pred;
  logic                r_pred_valid;

  logic                w_is_out;
  logic [CW-1:0]       w_size;
  logic                w_last;
  logic [DATA_W-1:0]   w_lane;

  assign w_is_out = (r_layer == OUT_IDX);
  assign w_size   = w_is_out ? OUT_SZ : HID_SZ;
  assign w_last   = (r_i == w_size - CW'(1));
  assign w_lane   = r_act[r_i];

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.load_done  = r_load_done;
  assign bus.pred       = r_pred;
  assign bus.pred_valid = r_pred_valid;
  assign bus.layer_idx  = r_layer;
  assign bus.dbg_state  = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state; start overrides everything, WAIT_LOW blocks re-triggering.
  always_comb begin
    w_next = r_state;
    if (bus.start) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (bus.load_en) w_next = S_CAPTURE;
        S_CAPTURE:  w_next = S_WRITE;
        S_WRITE:    if (w_last) w_next = S_DONE;
        S_DONE:     w_next = S_WAIT_LOW;
        S_WAIT_LOW: if (!bus.load_en) w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  // Snapshot of the parallel activation bus, frozen for the whole write burst.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE && !bus.start) begin
      for (int k = 0; k < NO_NHL; k++) r_act[k] <= bus.act_vec[k*DATA_W +: DATA_W];
    end
  end

  // Write sequencing, layer/base bookkeeping and running argmax.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i          <= '0;
      r_base       <= BASE0;
      r_layer      <= '0;
      r_max        <= '0;
      r_arg        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_load_done  <= 1'b0;
      r_pred       <= '0;
      r_pred_valid <= 1'b0;
    end else if (bus.start) begin
      r_base       <= BASE0;
      r_layer      <= '0;
      r_wr_en      <= 1'b0;
      r_load_done  <= 1'b0;
      r_pred       <= '0;
      r_pred_valid <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        S_CAPTURE: r_i <= '0;
        S_WRITE: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_base + ADDR_W'(r_i);
          r_wr_data <= w_lane;
          r_i       <= r_i + CW'(1);
          // Strict greater-than keeps the lowest index on ties.
          if (r_i == '0 || w_lane > r_max) begin
            r_max <= w_lane;
            r_arg <= r_i;
          end
        end
        S_DONE: begin
          r_load_done <= 1'b1;
          if (w_is_out) begin
            r_layer      <= '0;
            r_base       <= BASE0;
            r_pred       <= 4'(r_arg);
            r_pred_valid <= 1'b1;
          end else begin
            r_layer <= r_layer + LW'(1);
            r_base  <= r_base + ADDR_W'(w_size);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_act_loader.sv
// Directed bench for act_loader: full inferences, handshake hold-off,
// load_en drop, start abort, start/load_en collision and async reset.
module tb_act_loader;
  localparam int ST_IDLE     = 0;
  localparam int ST_WAIT_LOW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] lanes [28];

  act_loader_if bus ();

  act_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < 28; k++) bus.act_vec[k*8 +: 8] = lanes[k];
  endtask

  // One complete handshake; checks every cycle from request to return to IDLE.
  task automatic do_load(input int base, input int size, input int lidx_after,
                         input int exp_pv, input int drop_after, input int hold,
                         input bit with_start);
    pack();
    @(negedge clk);
    bus.load_en = 1'b1;
    bus.start   = with_start;
    if (with_start) begin
      @(negedge clk);
      chk("start_wins_state", bus.dbg_state, ST_IDLE);
      bus.start = 1'b0;
    end
    @(negedge clk);
    chk("capture_no_wr", bus.wr_en, 0);
    @(negedge clk);
    chk("first_write_cycle_no_wr", bus.wr_en, 0);
    for (int k = 0; k < size; k++) begin
      @(negedge clk);
      chk("wr_en", bus.wr_en, 1);
      chk("wr_addr", bus.wr_addr, base + k);
      chk("wr_data", bus.wr_data, lanes[k]);
      chk("no_early_done", bus.load_done, 0);
      if (k == 0) bus.act_vec = {28{8'hA5}};
      if (drop_after != 0 && k == drop_after - 1) bus.load_en = 1'b0;
    end
    @(negedge clk);
    chk("load_done", bus.load_done, 1);
    chk("wr_en_after_burst", bus.wr_en, 0);
    chk("layer_idx_after", bus.layer_idx, lidx_after);
    chk("pred_valid_at_done", bus.pred_valid, exp_pv);
    chk("state_wait_low", bus.dbg_state, ST_WAIT_LOW);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_no_wr", bus.wr_en, 0);
      chk("hold_no_done", bus.load_done, 0);
      chk("hold_state", bus.dbg_state, ST_WAIT_LOW);
    end
    bus.load_en = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", bus.load_done, 0);
    chk("back_to_idle", bus.dbg_state, ST_IDLE);
  endtask

  task automatic hid_a();
    for (int k = 0; k < 28; k++) lanes[k] = 8'(k + 1);
  endtask

  task automatic hid_b();
    for (int k = 0; k < 28; k++) lanes[k] = 8'(7 * k + 3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.load_en = 1'b0;
    bus.act_vec = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_load_done", bus.load_done, 0);
    chk("rst_pred", bus.pred, 0);
    chk("rst_pred_valid", bus.pred_valid, 0);
    chk("rst_layer_idx", bus.layer_idx, 0);
    chk("rst_state", bus.dbg_state, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);

    // Inference 1: hidden with 5-cycle hold, hidden with load_en drop, output.
    hid_a(); do_load(784, 28, 1, 0, 0, 5, 1'b0);
    hid_b(); do_load(812, 28, 2, 0, 3, 0, 1'b0);
    for (int k = 0; k < 28; k++) lanes[k] = 8'hFF;
    lanes[0] = 3; lanes[1] = 9; lanes[2] = 2; lanes[3] = 9; lanes[4] = 0;
    lanes[5] = 0; lanes[6] = 0; lanes[7] = 0; lanes[8] = 0; lanes[9] = 1;
    do_load(840, 10, 0, 1, 0, 0, 1'b0);
    chk("pred_tie_low", bus.pred, 1);
    chk("pred_valid_1", bus.pred_valid, 1);
    chk("layer_wrap", bus.layer_idx, 0);

    // Inference 2: base wraps to 784, pred/pred_valid hold meanwhile.
    hid_a(); do_load(784, 28, 1, 1, 0, 0, 1'b0);
    chk("pred_holds", bus.pred, 1);
    hid_b(); do_load(812, 28, 2, 1, 0, 0, 1'b0);
    for (int k = 0; k < 28; k++) lanes[k] = 8'hFF;
    lanes[0] = 199; lanes[1] = 50;
    for (int k = 2; k < 9; k++) lanes[k] = 0;
    lanes[9] = 200;
    do_load(840, 10, 0, 1, 0, 0, 1'b0);
    chk("pred_last_lane", bus.pred, 9);

    // Async reset during a layer-1 write burst.
    hid_a(); do_load(784, 28, 1, 1, 0, 0, 1'b0);
    hid_b(); pack();
    @(negedge clk);
    bus.load_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_wr_en", bus.wr_en, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_wr_en", bus.wr_en, 0);
    chk("async_rst_load_done", bus.load_done, 0);
    chk("async_rst_pred_valid", bus.pred_valid, 0);
    chk("async_rst_layer", bus.layer_idx, 0);
    chk("async_rst_state", bus.dbg_state, ST_IDLE);
    bus.load_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Inference 3 after reset, first load collides with start; all-zero output.
    hid_a(); do_load(784, 28, 1, 0, 0, 0, 1'b1);
    hid_b(); do_load(812, 28, 2, 0, 0, 0, 1'b0);
    for (int k = 0; k < 28; k++) lanes[k] = 8'hFF;
    for (int k = 0; k < 10; k++) lanes[k] = 0;
    do_load(840, 10, 0, 1, 0, 0, 1'b0);
    chk("pred_all_tie", bus.pred, 0);

    // start during the 10th write of layer 1 aborts the load.
    hid_a(); do_load(784, 28, 1, 1, 0, 0, 1'b0);
    hid_b(); pack();
    @(negedge clk);
    bus.load_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("tenth_write_en", bus.wr_en, 1);
    chk("tenth_write_addr", bus.wr_addr, 812 + 9);
    bus.start = 1'b1;
    bus.load_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_layer", bus.layer_idx, 0);
    chk("abort_pred_valid", bus.pred_valid, 0);
    chk("abort_state", bus.dbg_state, ST_IDLE);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      chk("abort_no_done", bus.load_done, 0);
      chk("abort_no_wr", bus.wr_en, 0);
    end
    hid_a(); do_load(784, 28, 1, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
